// File: rtl/truth_table_capture_if.sv
// Handshake bundle between the sweep controller, its start source and the DUT
// under lab test. Parameterised by the DUT input count N_IN.
interface truth_table_capture_if #(
    parameter int N_IN = 4
);
    localparam int TW = 2 ** N_IN;

    logic            start;
    logic [TW-1:0]   expected;
    logic            dut_out;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic [TW-1:0]   table_out;
    logic            match;
    logic [N_IN:0]   mismatch_cnt;
    logic [N_IN-1:0] first_err_idx;
    logic            err_valid;

    modport master (
        output start, expected, dut_out,
        input  vec, busy, done, table_out, match,
        input  mismatch_cnt, first_err_idx, err_valid
    );

    modport slave (
        input  start, expected, dut_out,
        output vec, busy, done, table_out, match,
        output mismatch_cnt, first_err_idx, err_valid
    );
endinterface

// File: rtl/truth_table_capture.sv
// Sweeps every N_IN-bit vector through a combinational DUT, captures its truth
// table and compares it with expected. Optional feature macro: TT_FIRST_ERR_EN.
module truth_table_capture #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic reset,
    truth_table_capture_if.slave bus
);
    localparam int TW = 2 ** N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VMAX = N_IN'(TW - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            match;
    logic [TW-1:0]   tbl;
    logic [TW-1:0]   tbl_next;
    logic [N_IN:0]   mcnt;
    logic            miss;
    logic            sample;

    // table including the bit being sampled this edge, so match sees it
    always_comb begin
        tbl_next      = tbl;
        tbl_next[vec] = bus.dut_out;
    end

    assign miss   = bus.dut_out != bus.expected[vec];
    assign sample = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            match <= 1'b0;
            tbl   <= '0;
            mcnt  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        vec   <= '0;
                        tbl   <= '0;
                        mcnt  <= '0;
                        match <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (sample) begin
                        tbl <= tbl_next;
                        cnt <= '0;
                        if (miss) mcnt <= mcnt + 1'b1;
                        if (vec == VMAX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (tbl_next == bus.expected);
                            state <= IDLE;
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vec          = vec;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.table_out    = tbl;
    assign bus.match        = match;
    assign bus.mismatch_cnt = mcnt;

`ifdef TT_FIRST_ERR_EN
    logic [N_IN-1:0] ferr;
    logic            evalid;

    // only the earliest mismatching vector of a sweep is kept
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr   <= '0;
            evalid <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ferr   <= '0;
            evalid <= 1'b0;
        end else if (sample && miss && !evalid) begin
            ferr   <= vec;
            evalid <= 1'b1;
        end
    end

    assign bus.first_err_idx = ferr;
    assign bus.err_valid     = evalid;
`else
    assign bus.first_err_idx = '0;
    assign bus.err_valid     = 1'b0;
`endif
endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench for truth_table_capture: a modelled DUT is swept, expected
// results are queued at start and compared when done pulses.
module tb_truth_table_capture;
    typedef struct {
        logic [15:0] tbl;
        logic        m;
        logic [4:0]  cnt;
        logic [3:0]  fidx;
        logic        fv;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   mode;
    int   n_run = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_capture_if #(.N_IN(4)) b1 ();
    truth_table_capture_if #(.N_IN(4)) b3 ();

    truth_table_capture #(.N_IN(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );
    truth_table_capture #(.N_IN(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(b3.slave)
    );

    function automatic logic f(int m, logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        if (m == 0) return ~(a & b & c & d);
        return ~a | ~b;
    endfunction

    assign b1.dut_out = f(mode, b1.vec);
    assign b3.dut_out = f(mode, b3.vec);

    function automatic exp_t model(int m, logic [15:0] e, int settle);
        exp_t r;
        r.tbl = '0; r.cnt = '0; r.fidx = '0; r.fv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r.tbl[i] = f(m, 4'(i));
            if (r.tbl[i] !== e[i]) begin
                r.cnt = r.cnt + 5'd1;
                if (!r.fv) begin
                    r.fv = 1'b1;
                    r.fidx = 4'(i);
                end
            end
        end
        r.m = (r.tbl === e);
        r.lat = settle * 16;
        return r;
    endfunction

    task automatic pulse_start1();
        b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
    endtask

    task automatic wait_done1(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            if (b1.done) begin
                when = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_run++;
        if ({b1.vec, b1.busy, b1.done, b1.match} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %0h want 0",
                     {b1.vec, b1.busy, b1.done, b1.match});
        end
        n_run++;
        if (b1.table_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_table: got %0h want 0", b1.table_out);
        end
        n_run++;
        if (b1.mismatch_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", b1.mismatch_cnt);
        end
        n_run++;
        if ({b1.first_err_idx, b1.err_valid} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_err: got %0h want 0",
                     {b1.first_err_idx, b1.err_valid});
        end
        n_run++;
        if ({b3.busy, b3.done, b3.vec} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_s3: got %0h want 0", {b3.busy, b3.done, b3.vec});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nand4();
        exp_t e;
        int k, w;
        mode = 0;
        b1.expected = 16'h7FFF;
        sb.push_back(model(0, 16'h7FFF, 1));
        pulse_start1();
        k = cyc;
        n_run++;
        if (b1.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy: got %b want 1", b1.busy);
        end
        wait_done1(40, w);
        e = sb.pop_front();
        n_run++;
        if (w - k != e.lat) begin
            n_fail++;
            $display("FAIL t1_latency: got %0d want %0d", w - k, e.lat);
        end
        n_run++;
        if (b1.table_out !== e.tbl) begin
            n_fail++;
            $display("FAIL t1_table: got %h want %h", b1.table_out, e.tbl);
        end
        n_run++;
        if ({b1.match, b1.mismatch_cnt} !== {e.m, e.cnt}) begin
            n_fail++;
            $display("FAIL t1_match_cnt: got %b/%0d want %b/%0d",
                     b1.match, b1.mismatch_cnt, e.m, e.cnt);
        end
        n_run++;
        if ({b1.busy, b1.vec} !== 5'h0F) begin
            n_fail++;
            $display("FAIL t1_end_state: got %h want 0f", {b1.busy, b1.vec});
        end
        n_run++;
        if (b1.err_valid !== e.fv) begin
            n_fail++;
            $display("FAIL t1_err_valid: got %b want %b", b1.err_valid, e.fv);
        end
        @(posedge clk); #1;
        n_run++;
        if (b1.done !== 1'b0 || b1.match !== e.m) begin
            n_fail++;
            $display("FAIL t1_done_pulse: got done=%b match=%b want 0/%b",
                     b1.done, b1.match, e.m);
        end
    endtask

    task automatic test_mismatch();
        exp_t e;
        int k, w;
        mode = 0;
        b1.expected = 16'h7FFE;
        sb.push_back(model(0, 16'h7FFE, 1));
        pulse_start1();
        k = cyc;
        wait_done1(40, w);
        e = sb.pop_front();
        n_run++;
        if (w - k != e.lat) begin
            n_fail++;
            $display("FAIL t2_latency: got %0d want %0d", w - k, e.lat);
        end
        n_run++;
        if ({b1.match, b1.mismatch_cnt} !== {e.m, e.cnt}) begin
            n_fail++;
            $display("FAIL t2_match_cnt: got %b/%0d want %b/%0d",
                     b1.match, b1.mismatch_cnt, e.m, e.cnt);
        end
`ifdef TT_FIRST_ERR_EN
        n_run++;
        if ({b1.err_valid, b1.first_err_idx} !== {e.fv, e.fidx}) begin
            n_fail++;
            $display("FAIL t2_first_err: got %b/%0d want %b/%0d",
                     b1.err_valid, b1.first_err_idx, e.fv, e.fidx);
        end
`else
        n_run++;
        if ({b1.err_valid, b1.first_err_idx} !== 5'd0) begin
            n_fail++;
            $display("FAIL t2_err_tied: got %b/%0d want 0/0",
                     b1.err_valid, b1.first_err_idx);
        end
`endif
    endtask

    task automatic test_restart_ignored();
        exp_t e;
        int k, w;
        mode = 1;
        b1.expected = 16'h0FFF;
        sb.push_back(model(1, 16'h0FFF, 1));
        pulse_start1();
        k = cyc;
        repeat (4) @(posedge clk);
        #1;
        pulse_start1();
        wait_done1(40, w);
        e = sb.pop_front();
        n_run++;
        if (w - k != e.lat) begin
            n_fail++;
            $display("FAIL t3_latency: got %0d want %0d", w - k, e.lat);
        end
        n_run++;
        if (b1.table_out !== e.tbl || b1.match !== e.m) begin
            n_fail++;
            $display("FAIL t3_result: got %h/%b want %h/%b",
                     b1.table_out, b1.match, e.tbl, e.m);
        end
        n_run++;
        if (b1.mismatch_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL t3_cnt: got %0d want %0d", b1.mismatch_cnt, e.cnt);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int k, w, seen;
        mode = 0;
        b1.expected = 16'h7FFF;
        pulse_start1();
        repeat (7) @(posedge clk);
        #1;
        n_run++;
        if (b1.table_out !== 16'h007F || b1.vec !== 4'd7) begin
            n_fail++;
            $display("FAIL t4_partial: got %h/%0d want 007f/7",
                     b1.table_out, b1.vec);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_run++;
        if ({b1.vec, b1.busy, b1.done, b1.match, b1.table_out,
             b1.mismatch_cnt, b1.err_valid} !== 29'd0) begin
            n_fail++;
            $display("FAIL t4_abort: got vec=%0d busy=%b done=%b tbl=%h",
                     b1.vec, b1.busy, b1.done, b1.table_out);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b1.done || b1.busy) seen++;
        end
        n_run++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL t4_no_done: got %0d active cycles want 0", seen);
        end
        sb.push_back(model(0, 16'h7FFF, 1));
        pulse_start1();
        k = cyc;
        wait_done1(40, w);
        e = sb.pop_front();
        n_run++;
        if (w - k != e.lat || b1.table_out !== e.tbl || b1.match !== e.m) begin
            n_fail++;
            $display("FAIL t4_rerun: got lat=%0d tbl=%h m=%b want %0d/%h/%b",
                     w - k, b1.table_out, b1.match, e.lat, e.tbl, e.m);
        end
    endtask

    task automatic test_settle3();
        exp_t e;
        int w, bad;
        mode = 0;
        b3.expected = 16'h7FFF;
        sb.push_back(model(0, 16'h7FFF, 3));
        b3.start = 1'b1;
        @(posedge clk); #1;
        b3.start = 1'b0;
        bad = 0;
        w = -1;
        for (int m = 1; m <= 100; m++) begin
            @(posedge clk); #1;
            if (b3.done) begin
                w = m;
                break;
            end
            if (b3.vec !== 4'(m / 3)) bad++;
        end
        e = sb.pop_front();
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL t5_vec_hold: got %0d bad cycles want 0", bad);
        end
        n_run++;
        if (w != e.lat) begin
            n_fail++;
            $display("FAIL t5_latency: got %0d want %0d", w, e.lat);
        end
        n_run++;
        if (b3.table_out !== e.tbl || b3.match !== e.m
            || b3.mismatch_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL t5_result: got %h/%b/%0d want %h/%b/%0d",
                     b3.table_out, b3.match, b3.mismatch_cnt,
                     e.tbl, e.m, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int d[$];
        logic prev;
        mode = 0;
        b1.expected = 16'h7FFF;
        b1.start = 1'b1;
        prev = b1.busy;
        for (int m = 0; m < 80; m++) begin
            @(posedge clk); #1;
            if (m == 39) b1.start = 1'b0;
            if (b1.busy && !prev) sb.push_back(model(0, 16'h7FFF, 1));
            if (b1.done) begin
                d.push_back(m);
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL t6_unexpected_done: got done at %0d want none", m);
                end else begin
                    e = sb.pop_front();
                    if (b1.table_out !== e.tbl || b1.match !== e.m) begin
                        n_fail++;
                        $display("FAIL t6_result: got %h/%b want %h/%b",
                                 b1.table_out, b1.match, e.tbl, e.m);
                    end
                end
            end
            prev = b1.busy;
        end
        n_run++;
        if (d.size() != 3) begin
            n_fail++;
            $display("FAIL t6_sweeps: got %0d want 3", d.size());
        end else begin
            n_run++;
            if (d[1] - d[0] != 17 || d[2] - d[1] != 17) begin
                n_fail++;
                $display("FAIL t6_spacing: got %0d,%0d want 17,17",
                         d[1] - d[0], d[2] - d[1]);
            end
        end
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL t6_drain: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        mode = 0;
        b1.start = 1'b0;
        b3.start = 1'b0;
        b1.expected = '0;
        b3.expected = '0;
        test_reset();
        test_nand4();
        test_mismatch();
        test_restart_ignored();
        test_reset_abort();
        test_settle3();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
